// File: rtl/ahb_apb_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ahb_apb_req_arbiter
// Purpose : Round-robin arbiter that shares the single AHB-lite slave port of
//           the AHB-to-APB bridge between NUM_REQ req/ack requesters. It runs
//           one single transfer at a time (address phase, then data phase).
//           It returns read data and the error status to the winning requester.
// Ports   : HCLK, HRESETn            clock, synchronous active-low reset
//           req/req_write/req_addr/
//           req_wdata                per-requester request bundle (flattened)
//           ack/rdata/err            completion pulse, read data, error flag
//           grant                    one-hot owner of the transfer in flight
//           HADDR/HWRITE/HTRANS/
//           HWDATA                   AHB-lite master outputs to the bridge
//           HREADY/HRDATA/HRESP      AHB-lite responses from the bridge
// Revision: 1.0 - initial release
// ============================================================================
module ahb_apb_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]         HADDR,
  output logic                          HWRITE,
  output logic [1:0]                    HTRANS,
  output logic [DATA_WIDTH-1:0]         HWDATA,
  input  logic                          HREADY,
  input  logic [DATA_WIDTH-1:0]         HRDATA,
  input  logic                          HRESP
);

  localparam int               IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0]       c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       c_HTRANS_NONSEQ = 2'b10;
  // Reset value of the last winner makes requester 0 the first one served.
  localparam logic [IDX_W-1:0] c_LAST_RESET    = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state_q,      state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]      grant_q,      grant_d;
  logic [NUM_REQ-1:0]      ack_q,        ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q,      rdata_d;
  logic                    err_q,        err_d;
  logic [ADDR_WIDTH-1:0]   haddr_q,      haddr_d;
  logic                    hwrite_q,     hwrite_d;
  logic [1:0]              htrans_q,     htrans_d;
  logic [DATA_WIDTH-1:0]   hwdata_q,     hwdata_d;
  logic [DATA_WIDTH-1:0]   wdata_lat_q,  wdata_lat_d;

  logic [NUM_REQ-1:0]      w_eligible;
  logic                    w_win_found;
  logic [IDX_W-1:0]        w_win_idx;
  logic [IDX_W-1:0]        w_cand;

  // Round-robin search starting just after the previous winner. A requester
  // whose ack is on the wire right now is masked, because it has not yet had
  // a chance to drop req for the transfer that just finished.
  always_comb begin : arbitrate
    w_eligible  = req & ~ack_q;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((int'(last_grant_q) + off) % NUM_REQ);
      if (!w_win_found && w_eligible[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ack_d        = '0;               // ack is a single-cycle pulse
    rdata_d      = rdata_q;
    err_d        = err_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    htrans_d     = htrans_q;
    hwdata_d     = hwdata_q;
    wdata_lat_d  = wdata_lat_q;

    case (state_q)
      ST_IDLE: begin
        if (w_win_found) begin
          // The request bundle is captured here; later changes on the
          // requester side cannot affect the transfer.
          grant_d      = NUM_REQ'(1) << w_win_idx;
          last_grant_d = w_win_idx;
          haddr_d      = req_addr[int'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          hwrite_d     = req_write[w_win_idx];
          wdata_lat_d  = req_wdata[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
          htrans_d     = c_HTRANS_NONSEQ;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = c_HTRANS_IDLE;
          hwdata_d = wdata_lat_q;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          if (!hwrite_q) begin
            rdata_d = HRDATA;
          end
          err_d   = HRESP;
          ack_d   = grant_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        htrans_d = c_HTRANS_IDLE;
        grant_d  = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin : regs
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= c_LAST_RESET;
      grant_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      htrans_q     <= c_HTRANS_IDLE;
      hwdata_q     <= '0;
      wdata_lat_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      htrans_q     <= htrans_d;
      hwdata_q     <= hwdata_d;
      wdata_lat_q  <= wdata_lat_d;
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign grant  = grant_q;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HTRANS = htrans_q;
  assign HWDATA = hwdata_q;

endmodule
`default_nettype wire
